updown_arbiter: RTL and testbench
=================================

# updown_arbiter

Shared up/down counter with two-requester round-robin arbitration. Each requester issues count-up, count-down, load or read commands over a valid/ready handshake. The block applies one command per cycle to an internal WIDTH-bit counter and returns the post-operation value on a single response channel tagged with the requester id. It sits between the command sources and the counter datapath, so that neither source drives the counter directly.

## Interface

- WIDTH, 32, counter and data width in bits
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- req0_valid  in  1  requester 0 has a command
- req0_op  in  2  00 up, 01 down, 10 load, 11 read
- req0_data  in  WIDTH  load value; ignored for other ops
- req0_ready  out  1  requester 0 command accepted this cycle
- req1_valid, req1_op, req1_data, req1_ready  same as requester 0, for requester 1
- resp_valid  out  1  response available
- resp_ready  in  1  response consumer accepts
- resp_id  out  1  requester that issued the answered command
- resp_value  out  WIDTH  counter value after the command
- resp_wrap  out  1  the command wrapped the counter
- value  out  WIDTH  live counter value (register output)

## Operation

- State:
  - counter register `value`
  - priority bit `prio` (0 = requester 0 favoured)
  - response register {resp_valid, resp_id, resp_value, resp_wrap}
- Stall: `stall = resp_valid && !resp_ready`. While stall is set, req0_ready = req1_ready = 0.
- Grant (combinational, when not stalled):
  - only one valid → that requester gets ready
  - both valid → requester `prio` gets ready; the other does not
  - at most one ready is high in any cycle
- Accept = valid && ready for the granted requester. On accept:
  - up: value ← value + 1 (mod 2^WIDTH); wrap = (old value == all-ones)
  - down: value ← value − 1 (mod 2^WIDTH); wrap = (old value == 0)
  - load: value ← data; wrap = 0
  - read: value unchanged; wrap = 0
  - resp_valid ← 1, resp_id ← winner, resp_value ← new value, resp_wrap ← wrap
  - prio ← ~winner
- Without a grant, value is unchanged (no free-running count).
- Response retires when resp_valid && resp_ready. If no new accept happens in the same cycle, resp_valid ← 0.
- prio changes only on accept. A lone requester may win on consecutive cycles.

## Timing

- Reset values: value = 0, prio = 0, resp_valid = 0, resp_id = 0, resp_value = 0, resp_wrap = 0.
- During reset, req*_ready = 0.
- Reset asserted mid-operation discards any pending response and any command presented in that cycle.
- Latency: accepted at edge N → value updated and resp_valid = 1 in cycle N+1.
- Throughput: 1 command per cycle while resp_ready = 1.
- Retire and accept in the same cycle are allowed. The response register reloads with the new command's result, and resp_valid stays 1.
- Stalled response: resp_id, resp_value and resp_wrap hold stable until retired.
- Unaccepted requesters must hold valid/op/data stable; the block does not latch unaccepted commands.
- value output and resp_value are equal in the cycle after any accept.

## Test plan

- Reset, then req0 up ×3 with resp_ready = 1 → resp_value 1, 2, 3 on consecutive cycles, resp_id = 0, value = 3.
- Both requesters valid continuously (req0 up, req1 down), value starts 10 → grants alternate 0, 1, 0, 1; resp_value 11, 10, 11, 10; resp_id 0, 1, 0, 1.
- req1 load 0xFFFFFFFF, then up → resp_value 0 with resp_wrap = 1. Then down → 0xFFFFFFFF with resp_wrap = 1. Load and read responses report resp_wrap = 0.
- resp_ready held 0 for 4 cycles with both valid → both readys low, response fields frozen, value unchanged. On release, the next grant goes to the requester opposite the last winner.
- Reset asserted while resp_valid = 1 and both valid → next cycle resp_valid = 0, value = 0, prio = 0. After deassert, a simultaneous request grants requester 0.
- req0 read with value 7 → resp_value 7, value stays 7, prio flips to 1.

Source files
------------

// File: rtl/updown_arbiter.sv
// updown_arbiter: shared WIDTH-bit up/down counter with two requesters.
// Requesters are arbitrated round-robin, one command is applied per cycle,
// and the post-operation value is returned on a single tagged response
// register that back-pressures both requesters while it is held.
module updown_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_value,
  output logic             resp_wrap,
  output logic [WIDTH-1:0] value
);

  localparam logic [1:0] OP_UP   = 2'b00;
  localparam logic [1:0] OP_DOWN = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  // Architectural state
  logic [WIDTH-1:0] value_reg;
  logic             prio_reg;
  logic             resp_valid_reg;
  logic             resp_id_reg;
  logic [WIDTH-1:0] resp_value_reg;
  logic             resp_wrap_reg;

  // Result of the command being accepted this cycle
  logic [WIDTH-1:0] value_next;
  logic             wrap_next;

  // Arbitration signals
  logic             stall;
  logic             grant_any;
  logic             winner;

  // Requester channels gathered into indexable form
  logic [1:0]       valid_vec;
  logic [1:0]       ready_vec;
  logic [1:0]       op_arr   [2];
  logic [WIDTH-1:0] data_arr [2];

  assign valid_vec   = {req1_valid, req0_valid};
  assign op_arr[0]   = req0_op;
  assign op_arr[1]   = req1_op;
  assign data_arr[0] = req0_data;
  assign data_arr[1] = req1_data;

  // Each requester is ready only when it is the granted winner; since at most
  // one winner exists, at most one ready can be high.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      localparam logic ID = 1'(gi);
      assign ready_vec[gi] = grant_any && (winner == ID);
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  // Round-robin grant; nothing is granted in reset or while a response is stuck.
  always_comb begin
    stall     = resp_valid_reg && !resp_ready;
    grant_any = 1'b0;
    winner    = 1'b0;
    if (!reset && !stall) begin
      if (&valid_vec) begin
        grant_any = 1'b1;
        winner    = prio_reg;
      end else if (valid_vec[0]) begin
        grant_any = 1'b1;
        winner    = 1'b0;
      end else if (valid_vec[1]) begin
        grant_any = 1'b1;
        winner    = 1'b1;
      end
    end
  end

  // Counter operation for the winning command; read leaves the value as is.
  always_comb begin
    value_next = value_reg;
    wrap_next  = 1'b0;
    case (op_arr[winner])
      OP_UP: begin
        value_next = value_reg + 1'b1;
        wrap_next  = &value_reg;
      end
      OP_DOWN: begin
        value_next = value_reg - 1'b1;
        wrap_next  = ~|value_reg;
      end
      OP_LOAD: begin
        value_next = data_arr[winner];
      end
      default: begin
        value_next = value_reg;
      end
    endcase
  end

  // State update: an accept reloads the response (even while one retires),
  // otherwise a retiring response simply drops valid and keeps its fields.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_reg      <= '0;
      prio_reg       <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_id_reg    <= 1'b0;
      resp_value_reg <= '0;
      resp_wrap_reg  <= 1'b0;
    end else if (grant_any) begin
      value_reg      <= value_next;
      prio_reg       <= ~winner;
      resp_valid_reg <= 1'b1;
      resp_id_reg    <= winner;
      resp_value_reg <= value_next;
      resp_wrap_reg  <= wrap_next;
    end else if (resp_valid_reg && resp_ready) begin
      resp_valid_reg <= 1'b0;
    end
  end

  assign value      = value_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_id    = resp_id_reg;
  assign resp_value = resp_value_reg;
  assign resp_wrap  = resp_wrap_reg;

endmodule

// File: tb/tb_updown_arbiter.sv
// Testbench for updown_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the counter and arbiter.
module tb_updown_arbiter;

  localparam int W = 32;
  localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         resp_valid, resp_ready, resp_id, resp_wrap;
  logic [W-1:0] resp_value, value;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] m_value;
  bit          m_prio;
  bit          m_rv, m_rid, m_rwrap;
  logic [63:0] m_rval;
  bit          acc0, acc1;

  always #5 clock = ~clock;

  updown_arbiter #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_value (resp_value),
    .resp_wrap  (resp_wrap),
    .value      (value)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input bit v, input logic [1:0] op, input logic [W-1:0] d);
    if (r == 0) begin
      req0_valid = v; req0_op = op; req0_data = d;
    end else begin
      req1_valid = v; req1_op = op; req1_data = d;
    end
  endtask

  // One clock cycle: predict grants, check readys, advance the model across
  // the rising edge, then check the registered outputs.
  task automatic step();
    bit g0, g1, win, stall;
    logic [1:0]  op;
    logic [63:0] d, sum;
    #1;
    stall = m_rv && !resp_ready;
    g0 = 0; g1 = 0;
    if (!reset && !stall) begin
      if (req0_valid && req1_valid) begin
        if (m_prio) g1 = 1; else g0 = 1;
      end else if (req0_valid) g0 = 1;
      else if (req1_valid) g1 = 1;
    end
    check("req0_ready", 64'(req0_ready), 64'(g0));
    check("req1_ready", 64'(req1_ready), 64'(g1));
    @(posedge clock);
    acc0 = 0; acc1 = 0;
    if (reset) begin
      m_value = 0; m_prio = 0; m_rv = 0; m_rid = 0; m_rval = 0; m_rwrap = 0;
    end else if (g0 || g1) begin
      win  = g1;
      acc0 = g0; acc1 = g1;
      op   = win ? req1_op : req0_op;
      d    = 64'(win ? req1_data : req0_data);
      m_rwrap = 0;
      case (op)
        2'd0: begin
          sum = m_value + 64'd1;
          m_rwrap = (sum > MASK);
          m_value = sum & MASK;
        end
        2'd1: begin
          m_rwrap = (m_value == 0);
          m_value = (m_value + MASK) & MASK;
        end
        2'd2: m_value = d;
        default: ;
      endcase
      m_rv = 1; m_rid = win; m_rval = m_value; m_prio = !win;
      $display("txn id=%0d op=%0d value=%0h wrap=%0d", win, op, m_value, m_rwrap);
    end else if (m_rv && resp_ready) begin
      m_rv = 0;
    end
    #1;
    check("value", 64'(value), m_value);
    check("resp_valid", 64'(resp_valid), 64'(m_rv));
    if (m_rv) begin
      check("resp_id", 64'(resp_id), 64'(m_rid));
      check("resp_value", 64'(resp_value), m_rval);
      check("resp_wrap", 64'(resp_wrap), 64'(m_rwrap));
    end
    @(negedge clock);
  endtask

  function automatic logic [W-1:0] rand_data();
    case ($urandom_range(0, 3))
      0: return '1;
      1: return '0;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    m_value = 0; m_prio = 0; m_rv = 0; m_rid = 0; m_rval = 0; m_rwrap = 0;
    reset = 1; resp_ready = 1;
    set_req(0, 0, 2'd0, '0);
    set_req(1, 0, 2'd0, '0);
    @(negedge clock);

    // Reset with commands presented: nothing granted, all state cleared
    set_req(0, 1, 2'd0, '0);
    set_req(1, 1, 2'd1, '0);
    step(); step();
    check("reset_value", 64'(value), 64'd0);
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    check("reset_resp_fields", 64'({resp_id, resp_wrap, resp_value}), 64'd0);
    reset = 0;
    set_req(1, 0, 2'd0, '0);

    // req0 up three times back to back
    set_req(0, 1, 2'd0, '0);
    step(); step(); step();
    check("up3_value", 64'(value), 64'd3);
    set_req(0, 0, 2'd0, '0);
    step();

    // Alternating grants from value 10
    set_req(1, 1, 2'd2, W'(10));
    step();
    set_req(0, 1, 2'd0, '0);
    set_req(1, 1, 2'd1, '0);
    step();
    check("alt_first_id", 64'(resp_id), 64'd0);
    check("alt_first_value", 64'(resp_value), 64'd11);
    step(); step(); step();
    check("alt_last_id", 64'(resp_id), 64'd1);
    check("alt_last_value", 64'(resp_value), 64'd10);
    set_req(0, 0, 2'd0, '0);

    // Wrap boundaries through requester 1
    set_req(1, 1, 2'd2, '1);
    step();
    check("load_wrap", 64'(resp_wrap), 64'd0);
    set_req(1, 1, 2'd0, '0);
    step();
    check("up_wrap_value", 64'(resp_value), 64'd0);
    check("up_wrap_flag", 64'(resp_wrap), 64'd1);
    set_req(1, 1, 2'd1, '0);
    step();
    check("down_wrap_value", 64'(resp_value), MASK);
    check("down_wrap_flag", 64'(resp_wrap), 64'd1);
    set_req(1, 1, 2'd3, '0);
    step();
    check("read_wrap", 64'(resp_wrap), 64'd0);
    set_req(1, 0, 2'd0, '0);

    // Stalled response with both requesters waiting, then release
    set_req(0, 1, 2'd0, '0);
    set_req(1, 1, 2'd1, '0);
    step();
    resp_ready = 0;
    step(); step(); step(); step();
    resp_ready = 1;
    step(); step();

    // Reset while a response is pending and both are valid
    reset = 1;
    step();
    check("midreset_resp_valid", 64'(resp_valid), 64'd0);
    check("midreset_value", 64'(value), 64'd0);
    reset = 0;
    step();
    check("post_reset_winner", 64'(resp_id), 64'd0);
    set_req(0, 0, 2'd0, '0);
    set_req(1, 0, 2'd0, '0);
    step();

    // Read with value 7 flips priority toward requester 1
    set_req(1, 1, 2'd2, W'(7));
    step();
    set_req(1, 0, 2'd0, '0);
    set_req(0, 1, 2'd3, '0);
    step();
    check("read7_value", 64'(resp_value), 64'd7);
    check("read7_counter", 64'(value), 64'd7);
    set_req(0, 1, 2'd0, '0);
    set_req(1, 1, 2'd0, '0);
    step();
    check("read7_next_winner", 64'(resp_id), 64'd1);

    // Random traffic; unaccepted commands are held stable
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid || acc0)
        set_req(0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rand_data());
      if (!req1_valid || acc1)
        set_req(1, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rand_data());
      resp_ready = ($urandom_range(0, 3) != 0);
      reset      = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
